fetch_target_queue: RTL and testbench
=====================================

Name: fetch_target_queue

Overview:
- Decoupling buffer directly downstream of the branch predictor.
- Each cycle it accepts one predicted fetch target (PC, last valid offset, prediction summary) and allocates its FetchID. It queues targets in order and hands them to the instruction-fetch/ICache stage under a valid/ready handshake.
- Its ready output is the predictor's pcValid, so it throttles prediction on queue-full or FetchID exhaustion.
- It flushes on mispredict and rewinds FetchID allocation.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_W, 31, halfword-granular PC width.
- OFF_W, 3, fetch offset width (FetchOff_t).
- FID_W, 3, FetchID width (FetchID_t).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- IN_mispr  in  1  mispredict/redirect; flushes the queue.
- IN_misprFetchID  in  FID_W  FetchID of the mispredicted packet.
- IN_comFetchID  in  FID_W  oldest FetchID not yet committed (frees IDs).
- IN_valid  in  1  predictor presents a target.
- IN_pc  in  PC_W  predicted fetch PC.
- IN_lastOffs  in  OFF_W  last valid offset of this packet.
- IN_predTaken  in  1  packet ends in a predicted-taken branch.
- IN_predOffs  in  OFF_W  offset of the predicted branch.
- OUT_ready  out  1  enqueue permitted (drives predictor pcValid).
- OUT_fetchID  out  FID_W  FetchID assigned to the current enqueue.
- OUT_valid  out  1  head entry valid toward fetch.
- OUT_pc, OUT_lastOffs, OUT_predTaken, OUT_predOffs, OUT_headFetchID  out  as above  head entry fields.
- IN_ready  in  1  fetch consumes the head this cycle.

Behaviour:
- Reset (rst == 0 at posedge):
  - rdPtr = wrPtr = count = 0, nextID = 0.
  - OUT_valid = 0; OUT_ready = 0 during reset, then 1 in the first cycle after release.
  - Reset mid-operation discards all entries, identical to a flush with nextID = 0.
- Enqueue:
  - enq = IN_valid && OUT_ready.
  - The entry is written at wrPtr with FetchID = nextID. OUT_fetchID = nextID combinationally.
  - On enq: nextID <= nextID + 1, mod 2^FID_W.
- Dequeue:
  - deq = OUT_valid && IN_ready. Head fields are driven from entry rdPtr.
  - OUT_valid = (count != 0). Fields are don't-care when OUT_valid = 0.
- Latency: enqueue to head visibility is 1 cycle when the queue is empty.
- OUT_ready = rst && !IN_mispr && (count != DEPTH) && !idFull.
  - Full-queue enqueue is blocked even if deq is asserted the same cycle (no pass-through when full).
- idFull: ((nextID - IN_comFetchID) mod 2^FID_W) == 2^FID_W - 1. At most 2^FID_W - 1 FetchIDs are outstanding, which protects predictor backup storage indexed by FetchID.
- Simultaneous enq and deq: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH (width log2(DEPTH)+1).
- Flush (IN_mispr = 1):
  - Priority over enq and deq in the same cycle.
  - Next edge: count = 0, rdPtr = wrPtr = 0, nextID <= IN_misprFetchID + 1 (mod).
  - OUT_valid = 0 the following cycle. The head may still be consumed in the flush cycle itself (fetch discards it by redirect).
- IN_comFetchID is sampled only for the combinational idFull. No state is kept for it.

Optional Feature:
- Macro: FTQ_BYPASS_EN.
- Defined: when count == 0, IN_valid && OUT_ready, and IN_ready, the input is forwarded combinationally to the head outputs in the same cycle.
  - OUT_valid = 1 and OUT_headFetchID = nextID.
  - The entry is not written; pointers do not move; nextID still increments.
  - No forwarding while IN_mispr is high.
- Not defined: 1-cycle minimum enqueue-to-head latency; head outputs come only from storage.

Decomposition:
- Shared package holds:
  - FetchID_t and FetchOff_t (existing).
  - FTQEntry_t packed struct {pc, lastOffs, predTaken, predOffs, fetchID}.
  - FTQ_DEPTH constant.
- Storage uses the codebase RegFile with 1 write port and 1 read port, width $bits(FTQEntry_t), DEPTH entries. Control and pointers stay in this module; no further sub-module.

Test Plan:
- Reset release, then IN_valid with pc = 0x40 and IN_ready = 1:
  - OUT_fetchID = 0 that cycle.
  - Next cycle OUT_valid = 1, OUT_pc = 0x40, OUT_headFetchID = 0.
- Hold IN_ready = 0 and push 4 targets pc = 0x10..0x13:
  - Queue full after 4 pushes; OUT_ready = 0.
  - On the 5th cycle IN_valid with IN_ready = 1: head pops 0x10 and no enqueue occurs; OUT_ready = 1 the next cycle.
- IN_comFetchID = 0 held, continuous enqueue with continuous dequeue:
  - After 7 allocations (IDs 0..6), OUT_ready = 0.
  - Setting IN_comFetchID = 3 reasserts OUT_ready; the next OUT_fetchID is 7, then 0 (wrap).
- 3 entries queued (IDs 2..4), then IN_mispr with IN_misprFetchID = 2 and IN_valid = 1 in the same cycle:
  - No enqueue.
  - Next cycle OUT_valid = 0, count = 0, and the next OUT_fetchID = 3.
- rst driven to 0 for 1 cycle with 2 entries queued:
  - OUT_valid = 0 and OUT_ready = 0 during reset.
  - After release, OUT_ready = 1 and OUT_fetchID = 0.
- With FTQ_BYPASS_EN, empty queue, IN_valid and IN_ready both 1, pc = 0x80:
  - Same cycle OUT_valid = 1 and OUT_pc = 0x80.
  - Next cycle count = 0 and OUT_fetchID incremented.
  - Without the macro, OUT_valid = 0 in the enqueue cycle.

Source files
------------

// File: rtl/fetch_target_queue_pkg.sv
// Shared fetch-side types: FetchID/FetchOff and the packed fetch-target entry.
// Widths here must agree with the fetch_target_queue parameter defaults.
package fetch_target_queue_pkg;

    localparam int FTQ_DEPTH = 4;
    localparam int FTQ_PC_W  = 31;
    localparam int FTQ_OFF_W = 3;
    localparam int FTQ_FID_W = 3;

    typedef logic [FTQ_FID_W-1:0] FetchID_t;
    typedef logic [FTQ_OFF_W-1:0] FetchOff_t;

    typedef struct packed {
        logic [FTQ_PC_W-1:0] pc;
        FetchOff_t           lastOffs;
        logic                predTaken;
        FetchOff_t           predOffs;
        FetchID_t            fetchID;
    } FTQEntry_t;

endpackage

// File: rtl/fetch_target_queue_regfile.sv
// Register file: 1 synchronous write port, 1 combinational read port, no reset.
// Read data reflects a write only after the writing edge.
module fetch_target_queue_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_target_queue.sv
// In-order queue of predicted fetch targets between branch predictor and ICache fetch; allocates FetchIDs.
// Optional FTQ_BYPASS_EN forwards an enqueue straight to the head when empty and fetch is ready.
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH,
    parameter int PC_W  = FTQ_PC_W,
    parameter int OFF_W = FTQ_OFF_W,
    parameter int FID_W = FTQ_FID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_mispr,
    input  logic [FID_W-1:0] IN_misprFetchID,
    input  logic [FID_W-1:0] IN_comFetchID,
    input  logic             IN_valid,
    input  logic [PC_W-1:0]  IN_pc,
    input  logic [OFF_W-1:0] IN_lastOffs,
    input  logic             IN_predTaken,
    input  logic [OFF_W-1:0] IN_predOffs,
    output logic             OUT_ready,
    output logic [FID_W-1:0] OUT_fetchID,
    output logic             OUT_valid,
    output logic [PC_W-1:0]  OUT_pc,
    output logic [OFF_W-1:0] OUT_lastOffs,
    output logic             OUT_predTaken,
    output logic [OFF_W-1:0] OUT_predOffs,
    output logic [FID_W-1:0] OUT_headFetchID,
    input  logic             IN_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [FID_W-1:0] next_id_q, next_id_d;

    logic [FID_W-1:0] id_diff;
    logic             id_full;
    logic             q_full;
    logic             q_nonempty;
    logic             enq;
    logic             byp;
    logic             wr_st;
    logic             deq_st;
    FTQEntry_t        wr_entry;
    FTQEntry_t        rd_entry;

    // Keeping one FetchID unallocated protects predictor backup storage indexed by FetchID.
    assign id_diff    = next_id_q - IN_comFetchID;
    assign id_full    = &id_diff;
    assign q_full     = (count_q == CNT_W'(DEPTH));
    assign q_nonempty = rst && (count_q != '0);

    assign OUT_ready   = rst && !IN_mispr && !q_full && !id_full;
    assign OUT_fetchID = next_id_q;
    assign enq         = IN_valid && OUT_ready;

`ifdef FTQ_BYPASS_EN
    assign byp = enq && IN_ready && (count_q == '0);
`else
    assign byp = 1'b0;
`endif

    assign wr_st  = enq && !byp;
    assign deq_st = q_nonempty && IN_ready;

    always_comb begin
        wr_entry           = '0;
        wr_entry.pc        = IN_pc;
        wr_entry.lastOffs  = IN_lastOffs;
        wr_entry.predTaken = IN_predTaken;
        wr_entry.predOffs  = IN_predOffs;
        wr_entry.fetchID   = next_id_q;
    end

    fetch_target_queue_regfile #(
        .WIDTH ($bits(FTQEntry_t)),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .we_i    (wr_st),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        OUT_valid       = q_nonempty;
        OUT_pc          = rd_entry.pc;
        OUT_lastOffs    = rd_entry.lastOffs;
        OUT_predTaken   = rd_entry.predTaken;
        OUT_predOffs    = rd_entry.predOffs;
        OUT_headFetchID = rd_entry.fetchID;
        if (byp) begin
            OUT_valid       = 1'b1;
            OUT_pc          = IN_pc;
            OUT_lastOffs    = IN_lastOffs;
            OUT_predTaken   = IN_predTaken;
            OUT_predOffs    = IN_predOffs;
            OUT_headFetchID = next_id_q;
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        next_id_d = next_id_q;
        // A flush overrides any same-cycle enqueue/dequeue and rewinds allocation past the mispredicted packet.
        if (IN_mispr) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            next_id_d = IN_misprFetchID + FID_W'(1);
        end else begin
            if (enq)    next_id_d = next_id_q + FID_W'(1);
            if (wr_st)  wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            if (deq_st) rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            case ({wr_st, deq_st})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            next_id_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            next_id_q <= next_id_d;
        end
    end

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue; expectations follow the build (FTQ_BYPASS_EN or not).
module tb_fetch_target_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_mispr;
    logic [2:0]  IN_misprFetchID;
    logic [2:0]  IN_comFetchID;
    logic        IN_valid;
    logic [30:0] IN_pc;
    logic [2:0]  IN_lastOffs;
    logic        IN_predTaken;
    logic [2:0]  IN_predOffs;
    logic        OUT_ready;
    logic [2:0]  OUT_fetchID;
    logic        OUT_valid;
    logic [30:0] OUT_pc;
    logic [2:0]  OUT_lastOffs;
    logic        OUT_predTaken;
    logic [2:0]  OUT_predOffs;
    logic [2:0]  OUT_headFetchID;
    logic        IN_ready;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_target_queue dut (
        .clk             (clk),
        .rst             (rst),
        .IN_mispr        (IN_mispr),
        .IN_misprFetchID (IN_misprFetchID),
        .IN_comFetchID   (IN_comFetchID),
        .IN_valid        (IN_valid),
        .IN_pc           (IN_pc),
        .IN_lastOffs     (IN_lastOffs),
        .IN_predTaken    (IN_predTaken),
        .IN_predOffs     (IN_predOffs),
        .OUT_ready       (OUT_ready),
        .OUT_fetchID     (OUT_fetchID),
        .OUT_valid       (OUT_valid),
        .OUT_pc          (OUT_pc),
        .OUT_lastOffs    (OUT_lastOffs),
        .OUT_predTaken   (OUT_predTaken),
        .OUT_predOffs    (OUT_predOffs),
        .OUT_headFetchID (OUT_headFetchID),
        .IN_ready        (IN_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs change 1 time unit later, outputs are checked 2 units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; IN_mispr = 1'b0; IN_misprFetchID = '0; IN_comFetchID = '0;
        IN_valid = 1'b0; IN_pc = '0; IN_lastOffs = '0; IN_predTaken = 1'b0;
        IN_predOffs = '0; IN_ready = 1'b0;

        tick(); tick();
        settle();
        chk("rst_valid", 32'(OUT_valid), 32'd0);
        chk("rst_ready", 32'(OUT_ready), 32'd0);
        rst = 1'b1;
        settle();
        chk("rel_ready", 32'(OUT_ready), 32'd1);
        chk("rel_fid", 32'(OUT_fetchID), 32'd0);

        // First enqueue with fetch ready
        IN_valid = 1'b1; IN_pc = 31'h40; IN_lastOffs = 3'd5; IN_predTaken = 1'b1;
        IN_predOffs = 3'd3; IN_ready = 1'b1;
        settle();
        chk("enq0_fid", 32'(OUT_fetchID), 32'd0);
`ifdef FTQ_BYPASS_EN
        chk("enq0_byp_valid", 32'(OUT_valid), 32'd1);
        chk("enq0_byp_pc", 32'(OUT_pc), 32'h40);
        chk("enq0_byp_hfid", 32'(OUT_headFetchID), 32'd0);
`else
        chk("enq0_valid", 32'(OUT_valid), 32'd0);
`endif
        tick();
        IN_valid = 1'b0;
        settle();
        chk("enq0_next_fid", 32'(OUT_fetchID), 32'd1);
`ifdef FTQ_BYPASS_EN
        chk("enq0_byp_empty", 32'(OUT_valid), 32'd0);
`else
        chk("head0_valid", 32'(OUT_valid), 32'd1);
        chk("head0_pc", 32'(OUT_pc), 32'h40);
        chk("head0_hfid", 32'(OUT_headFetchID), 32'd0);
        chk("head0_loffs", 32'(OUT_lastOffs), 32'd5);
        chk("head0_taken", 32'(OUT_predTaken), 32'd1);
        chk("head0_poffs", 32'(OUT_predOffs), 32'd3);
`endif
        tick();
        settle();
        chk("drained0", 32'(OUT_valid), 32'd0);

        // Fill the queue with fetch stalled; IDs 1..4
        IN_ready = 1'b0; IN_predTaken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IN_valid = 1'b1; IN_pc = 31'(32'h10 + i);
            settle();
            chk("fill_ready", 32'(OUT_ready), 32'd1);
            chk("fill_fid", 32'(OUT_fetchID), 32'(1 + i));
            tick();
        end
        IN_pc = 31'h14; IN_ready = 1'b1;
        settle();
        chk("full_ready", 32'(OUT_ready), 32'd0);
        chk("full_head_pc", 32'(OUT_pc), 32'h10);
        chk("full_head_hfid", 32'(OUT_headFetchID), 32'd1);
        tick();
        IN_valid = 1'b0; IN_ready = 1'b0;
        settle();
        chk("after_full_ready", 32'(OUT_ready), 32'd1);
        chk("after_full_fid", 32'(OUT_fetchID), 32'd5);
        IN_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("drain_valid", 32'(OUT_valid), 32'd1);
            chk("drain_pc", 32'(OUT_pc), 32'(32'h11 + i));
            chk("drain_hfid", 32'(OUT_headFetchID), 32'(2 + i));
            tick();
        end
        settle();
        chk("drain_empty", 32'(OUT_valid), 32'd0);

        // Rewind IDs to 0 via a mispredict on ID 7, then exhaust FetchIDs
        IN_mispr = 1'b1; IN_misprFetchID = 3'd7;
        tick();
        IN_mispr = 1'b0;
        settle();
        chk("rewind_fid", 32'(OUT_fetchID), 32'd0);
        IN_valid = 1'b1; IN_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            IN_pc = 31'(32'h100 + i);
            settle();
            chk("alloc_ready", 32'(OUT_ready), 32'd1);
            chk("alloc_fid", 32'(OUT_fetchID), 32'(i));
            tick();
        end
        settle();
        chk("idfull_ready", 32'(OUT_ready), 32'd0);
        IN_comFetchID = 3'd3;
        settle();
        chk("idfree_ready", 32'(OUT_ready), 32'd1);
        chk("idfree_fid7", 32'(OUT_fetchID), 32'd7);
        tick();
        settle();
        chk("idwrap_fid0", 32'(OUT_fetchID), 32'd0);
        tick();
        IN_valid = 1'b0;
        tick(); tick();
        IN_comFetchID = 3'd0;
        settle();
        chk("alloc_drained", 32'(OUT_valid), 32'd0);

        // Queue IDs 2..4, then flush with a competing enqueue
        IN_mispr = 1'b1; IN_misprFetchID = 3'd1;
        tick();
        IN_mispr = 1'b0; IN_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IN_valid = 1'b1; IN_pc = 31'(32'h20 + i);
            settle();
            chk("pre_flush_fid", 32'(OUT_fetchID), 32'(2 + i));
            tick();
        end
        IN_pc = 31'h30; IN_mispr = 1'b1; IN_misprFetchID = 3'd2;
        settle();
        chk("flush_head_hfid", 32'(OUT_headFetchID), 32'd2);
        chk("flush_ready", 32'(OUT_ready), 32'd0);
        tick();
        IN_mispr = 1'b0; IN_valid = 1'b0;
        settle();
        chk("post_flush_valid", 32'(OUT_valid), 32'd0);
        chk("post_flush_fid", 32'(OUT_fetchID), 32'd3);
        chk("post_flush_ready", 32'(OUT_ready), 32'd1);

        // Reset with two entries queued
        for (int i = 0; i < 2; i++) begin
            IN_valid = 1'b1; IN_pc = 31'(32'h50 + i);
            tick();
        end
        IN_valid = 1'b0;
        settle();
        chk("pre_rst_valid", 32'(OUT_valid), 32'd1);
        chk("pre_rst_pc", 32'(OUT_pc), 32'h50);
        rst = 1'b0;
        settle();
        chk("mid_rst_valid", 32'(OUT_valid), 32'd0);
        chk("mid_rst_ready", 32'(OUT_ready), 32'd0);
        tick();
        rst = 1'b1;
        settle();
        chk("post_rst_ready", 32'(OUT_ready), 32'd1);
        chk("post_rst_fid", 32'(OUT_fetchID), 32'd0);
        chk("post_rst_valid", 32'(OUT_valid), 32'd0);

        // Empty queue with fetch ready: forwarding in bypass builds only
        IN_valid = 1'b1; IN_ready = 1'b1; IN_pc = 31'h80;
        settle();
`ifdef FTQ_BYPASS_EN
        chk("byp_valid", 32'(OUT_valid), 32'd1);
        chk("byp_pc", 32'(OUT_pc), 32'h80);
`else
        chk("nobyp_valid", 32'(OUT_valid), 32'd0);
`endif
        tick();
        IN_valid = 1'b0; IN_ready = 1'b0;
        settle();
        chk("byp_next_fid", 32'(OUT_fetchID), 32'd1);
`ifdef FTQ_BYPASS_EN
        chk("byp_not_stored", 32'(OUT_valid), 32'd0);
`else
        chk("nobyp_head_valid", 32'(OUT_valid), 32'd1);
        chk("nobyp_head_pc", 32'(OUT_pc), 32'h80);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
